// File: rtl/div_mul_pkg.sv
// Shared widths and state encoding for the 16-by-8 divider and its
// reconstructing multiplier.
package div_mul_pkg;

    localparam int A_W   = 16;
    localparam int B_W   = 8;
    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(B_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the multiplier: conditionally add the
// multiplicand, then advance multiplicand left and multiplier right.
module mul_step
    import div_mul_pkg::*;
(
    input  logic [P_W-1:0] acc,
    input  logic [P_W-1:0] mcand,
    input  logic [B_W-1:0] mplier,
    output logic [P_W-1:0] acc_next,
    output logic [P_W-1:0] mcand_next,
    output logic [B_W-1:0] mplier_next
);

    // Add only when the current multiplier LSB is set; the sum never
    // exceeds P_W bits, so no carry is kept.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule

// File: rtl/mul_16bit_recon.sv
// Sequential shift-add multiplier rebuilding a dividend: result = Q*B + R.
// Fixed B_W iterations per transaction, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand set
//   CALC  | one shift-add iteration per cycle, B_W cycles
//   DONE  | out_valid high, outputs held until out_ready
module mul_16bit_recon
    import div_mul_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] Q,
    input  logic [B_W-1:0] B,
    input  logic [A_W-1:0] R,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] result,
    output logic           rem_ok,
    output logic           fits16
);

    state_t           state;
    state_t           state_d;
    logic [P_W-1:0]   acc;
    logic [P_W-1:0]   mcand;
    logic [B_W-1:0]   mplier;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   acc_next;
    logic [P_W-1:0]   mcand_next;
    logic [B_W-1:0]   mplier_next;
    logic             last_iter;

    assign last_iter = (cnt == CNT_W'(B_W - 1));

    mul_step u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and handshake outputs, decoded from state only.
    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, capture the
    // final sum into the result register on the last iteration so outputs
    // stay still while DONE waits for the consumer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
            rem_ok <= 1'b0;
            fits16 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= {{B_W{1'b0}}, R};
                        mcand  <= {{B_W{1'b0}}, Q};
                        mplier <= B;
                        cnt    <= '0;
                        rem_ok <= (B != '0) && (R < {{(A_W - B_W){1'b0}}, B});
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        result <= acc_next;
                        fits16 <= (acc_next[P_W-1:A_W] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_16bit_recon.sv
// Directed-vector bench for the Q*B+R reconstructing multiplier.
module tb_mul_16bit_recon;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Q;
    logic [7:0]  B;
    logic [15:0] R;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
    logic        rem_ok;
    logic        fits16;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  b;
        logic [15:0] r;
        logic [23:0] exp_result;
        logic        exp_rem_ok;
        logic        exp_fits16;
    } vec_t;

    vec_t vecs[9];

    mul_16bit_recon dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Q         (Q),
        .B         (B),
        .R         (R),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rem_ok    (rem_ok),
        .fits16    (fits16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present an operand set at a falling edge and let it be taken on the
    // next rising edge; scramble operands afterwards, which must not matter.
    task automatic accept(input logic [15:0] q, input logic [7:0] b, input logic [15:0] r);
        @(negedge clk);
        chk("in_ready_before_accept", in_ready, 1);
        Q = q; B = b; R = r; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Q = 16'($urandom); B = 8'($urandom); R = 16'($urandom);
    endtask

    // Count rising edges until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, in_ready, 1);
        chk({name, "_out_valid_after"}, out_valid, 0);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        accept(v.q, v.b, v.r);
        wait_valid(lat);
        chk({name, "_latency"}, lat, 8);
        chk({name, "_result"}, result, v.exp_result);
        chk({name, "_rem_ok"}, rem_ok, v.exp_rem_ok);
        chk({name, "_fits16"}, fits16, v.exp_fits16);
        chk({name, "_in_ready_done"}, in_ready, 0);
        release_result(name);
    endtask

    initial begin
        int lat;
        logic [23:0] held;

        vecs[0] = '{16'h1234, 8'h56, 16'h0010, 24'h061D88, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 8'hFF, 16'hFFFF, 24'hFFFF00, 1'b0, 1'b0};
        vecs[2] = '{16'hABCD, 8'h00, 16'h0005, 24'h000005, 1'b0, 1'b1};
        vecs[3] = '{16'd142,  8'd7,  16'd6,    24'h0003E8, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 8'h01, 16'h0000, 24'h000000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 8'h02, 16'h0001, 24'h01FFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 8'h80, 16'h007F, 24'h40007F, 1'b1, 1'b0};
        vecs[7] = '{16'h0001, 8'h03, 16'h0003, 24'h000006, 1'b0, 1'b1};
        vecs[8] = '{16'h00FF, 8'h01, 16'h0000, 24'h0000FF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Q = '0; B = '0; R = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_rem_ok", rem_ok, 0);
        chk("reset_fits16", fits16, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Round trip through a bench-side divider model.
        for (int i = 0; i < 12; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            vec_t v;
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            v.q = a / {8'h00, b};
            v.b = b;
            v.r = a % {8'h00, b};
            v.exp_result = {8'h00, a};
            v.exp_rem_ok = 1'b1;
            v.exp_fits16 = 1'b1;
            run_vec($sformatf("trip%0d", i), v);
        end

        // Backpressure: DONE held with in_valid asserted.
        accept(16'h1234, 8'h56, 16'h0010);
        wait_valid(lat);
        chk("bp_latency", lat, 8);
        Q = 16'h0001; B = 8'h01; R = 16'h0000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_out_valid%0d", i), out_valid, 1);
            chk($sformatf("bp_result%0d", i), result, 24'h061D88);
            chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_out_valid_after", out_valid, 0);
        held = result;
        @(posedge clk);
        #1;
        chk("bp_no_new_accept", in_ready, 1);
        chk("bp_result_kept", result, 24'h061D88);

        // Reset sampled on the 4th CALC edge.
        accept(16'hFFFF, 8'hFF, 16'hFFFF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_rem_ok", rem_ok, 0);
        run_vec("after_rst", vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_16bit_recon.md
# mul_16bit_recon

Sequential shift-add multiplier that reconstructs a dividend from a divider's quotient, divisor and remainder: result = Q × B + R. It sits on the output side of the 16-by-8 divider datapath and is used as its inverse: for round-trip checks, and wherever a dividend must be rebuilt from stored quotient/remainder pairs. It takes one operand set per transaction over a valid/ready handshake and delivers a 24-bit result after a fixed 8-iteration computation.

## Interface
- A_W, 16, quotient width (and remainder width)
- B_W, 8, divisor width; also the iteration count
- P_W = A_W + B_W (24), result width; derived, not overridable
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept; high only in IDLE
- Q  in  A_W  quotient
- B  in  B_W  divisor
- R  in  A_W  remainder
- out_valid  out  1  result available; held until taken
- out_ready  in  1  consumer takes result
- result  out  P_W  Q×B+R
- rem_ok  out  1  B≠0 and R<B, i.e. a legal divider output pair
- fits16  out  1  result[P_W-1:A_W]==0, i.e. the dividend fits A_W bits

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch operands: acc←{8'b0,R}, mcand←{8'b0,Q}, mplier←B, cnt←0, rem_ok computed from the latched B and R. Go to CALC.
- CALC: each cycle, if mplier[0] then acc←acc+mcand. Also mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1. After the iteration with cnt==B_W-1, go to DONE.
- No early exit on mplier==0: latency is fixed.
- DONE: out_valid=1. result=acc, fits16 from acc. All outputs hold stable until out_valid&out_ready, then go to IDLE.
- Arithmetic is unsigned throughout. The worst case 0xFFFF×0xFF+0xFFFF = 0xFFFF00 fits in 24 bits, so there is no overflow and no carry out is kept.
- B=0: result=R, rem_ok=0. This is not an error and has no special path.
- In_valid is ignored outside IDLE. Operand changes after accept have no effect.
- Reset (rst_n low at an edge) returns the block to IDLE from any state, including mid-CALC and DONE. Any in-flight transaction is discarded silently.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, result=0, rem_ok=0, fits16=0; internal acc, mcand, mplier, cnt = 0.
- Accept on edge E0. CALC iterations occur on edges E1..E8. out_valid rises after E8, so the latency is 8 cycles from accept to out_valid.
- The DONE→IDLE transition happens on the edge where out_ready is sampled high. in_ready is high the following cycle.
- There is no back-to-back acceptance. The minimum initiation interval is 10 cycles (accept, 8 CALC, 1 DONE with out_ready=1).
- out_ready is ignored outside DONE.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Structure
- Shared package div_mul_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - localparams A_W=16, B_W=8, P_W=24;
  - CNT_W=$clog2(B_W).
- The divider will import the same width constants.
- One sub-module is natural: mul_step (combinational, one shift-add iteration: acc, mcand, mplier in → next values out). The top holds the FSM, the registers and the handshake.

## Test plan
- Q=0x1234, B=0x56, R=0x0010 → result=0x061D88, rem_ok=1, fits16=0. out_valid rises exactly 8 cycles after accept.
- Q=0xFFFF, B=0xFF, R=0xFFFF → result=0xFFFF00, rem_ok=0, fits16=0, no wrap.
- Q=0xABCD, B=0x00, R=0x0005 → result=0x000005, rem_ok=0, fits16=1.
- Divider round-trip: A=1000, B=7 gives Q=142, R=6 → result=0x0003E8, rem_ok=1, fits16=1. Then sweep random A and B≠0 through the divider and this block, and require result==A with rem_ok=1 on every vector.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 → out_valid and result stable, in_ready=0, no new accept. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-operation: drive rst_n low on the 4th CALC cycle → the next cycle shows in_ready=1, out_valid=0, result=0. A fresh transaction afterwards completes correctly with 8-cycle latency.
